l_stf_seq: RTL and testbench

- Sequencer for the 16-entry L-STF sample ROM in the openofdm_tx preamble path.
- On a start pulse, it walks the ROM address NUM_REP times: 10 x 16 = 160 samples, i.e. 8 us at 20 MS/s.
- It presents each 32-bit I/Q sample on a valid/ready stream toward the TX sample mux.
- It optionally halves the first sample for symbol-edge windowing, and reports busy/done to the TX control FSM.

---
 rtl/l_stf_seq.sv | 133 +++++++++++++
 tb/tb_l_stf_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l_stf_seq.sv
// l_stf_seq -- L-STF sample sequencer for the OFDM TX preamble path.
//
// Walks a 16-entry combinational L-STF ROM NUM_REP times after a start
// pulse and streams each 32-bit I/Q sample on a valid/ready interface.
// When WIN_EN is set, the very first sample of a field is halved (I and Q
// each arithmetic-shifted right by 1) for symbol-edge windowing.
//
// Ports:
//   clk          : TX clock
//   phy_tx_arest : synchronous active-high reset
//   start        : one-cycle field request, honoured only when idle
//   abort        : synchronous cancel, overrides every other event
//   rom_addr     : L-STF ROM address (cnt[3:0], 0 while idle)
//   rom_dout     : ROM sample, [31:16] I, [15:0] Q, signed 16-bit each
//   m_tdata      : output sample, same packing as rom_dout
//   m_tvalid     : output sample valid
//   m_tready     : downstream accept
//   m_tlast      : marks the final sample of the field
//   busy         : field in progress
//   done         : one-cycle pulse after the final sample handshake
module l_stf_seq #(
   parameter int unsigned NUM_REP = 10,
   parameter bit          WIN_EN  = 1'b1
) (
   input  logic        clk,
   input  logic        phy_tx_arest,
   input  logic        start,
   input  logic        abort,
   output logic [3:0]  rom_addr,
   input  logic [31:0] rom_dout,
   output logic [31:0] m_tdata,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic        m_tlast,
   output logic        busy,
   output logic        done
);

   localparam logic [7:0] LAST_IDX = 8'(NUM_REP * 16 - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_cnt;
   logic [31:0] r_tdata;
   logic        r_tvalid;
   logic        r_tlast;
   logic        r_done;

   logic        w_hs;
   logic        w_load;
   logic        w_final;
   logic [31:0] w_sample;

   // Next-state and load/finish decode
   always_comb begin
      w_state_nxt = r_state;
      w_hs        = r_tvalid & m_tready;
      w_load      = 1'b0;
      w_final     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start && !abort) begin
               w_load      = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               w_state_nxt = IDLE;
            end else if (w_hs && r_tlast) begin
               // The presented sample carries m_tlast, so this handshake
               // is the last one of the field.
               w_final     = 1'b1;
               w_state_nxt = IDLE;
            end else if (w_hs) begin
               w_load      = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Windowing applies only to global sample 0 (cnt still 0 at its load).
   always_comb begin
      w_sample = rom_dout;
      if (WIN_EN && (r_cnt == '0)) begin
         w_sample = {rom_dout[31], rom_dout[31:17], rom_dout[15], rom_dout[15:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (phy_tx_arest) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (phy_tx_arest) begin
         r_cnt    <= '0;
         r_tdata  <= '0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= w_final;
         if (abort || w_final) begin
            r_cnt    <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
         end else if (w_load) begin
            r_tdata  <= w_sample;
            r_tlast  <= (r_cnt == LAST_IDX);
            r_tvalid <= 1'b1;
            r_cnt    <= r_cnt + 8'd1;
         end
      end
   end

   assign rom_addr = r_cnt[3:0];
   assign m_tdata  = r_tdata;
   assign m_tvalid = r_tvalid;
   assign m_tlast  = r_tlast;
   assign busy     = (r_state == RUN);
   assign done     = r_done;

endmodule

// File: tb/tb_l_stf_seq.sv
// Scoreboard bench for l_stf_seq: default instance (NUM_REP=10, WIN_EN=1)
// and a short instance (NUM_REP=2, WIN_EN=0), each fed by a ROM model.
module tb_l_stf_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start_a, abort_a, tready_a;
   logic [3:0]  addr_a;
   logic [31:0] rom_a, tdata_a;
   logic        tvalid_a, tlast_a, busy_a, done_a;
   logic        start_b, abort_b, tready_b;
   logic [3:0]  addr_b;
   logic [31:0] rom_b, tdata_b;
   logic        tvalid_b, tlast_b, busy_b, done_b;

   int checks = 0;
   int errors = 0;
   int beats_a = 0, beats_b = 0, dones_a = 0, dones_b = 0;
   logic [32:0] q_a[$];
   logic [32:0] q_b[$];

   function automatic logic [31:0] rom_f(input logic [3:0] a);
      case (a)
         4'd0:  return 32'hfd0efd0e;
         4'd1:  return 32'h0000fbd6;
         4'd2:  return 32'hff2a0013;
         4'd3:  return 32'h042a0000;
         4'd4:  return 32'h02440244;
         4'd5:  return 32'h0000042a;
         4'd6:  return 32'h0013ff2a;
         4'd7:  return 32'h0244fdbc;
         4'd8:  return 32'h02f202f2;
         4'd9:  return 32'h00f00123;
         4'd10: return 32'hfdbc0244;
         4'd11: return 32'h042afbd6;
         4'd12: return 32'h01230456;
         4'd13: return 32'hff000100;
         4'd14: return 32'h7fff8000;
         default: return 32'hfbd60000;
      endcase
   endfunction

   assign rom_a = rom_f(addr_a);
   assign rom_b = rom_f(addr_b);

   // Expected {tlast, data} of beat k; windowed beat 0 is hand-computed.
   function automatic logic [32:0] exp_beat(input int unsigned k, input int unsigned nrep, input bit win);
      logic [31:0] s;
      s = rom_f(4'(k % 16));
      if (win && k == 0) s = 32'hfe87fe87;
      return {(k == nrep * 16 - 1), s};
   endfunction

   l_stf_seq #(.NUM_REP(10), .WIN_EN(1'b1)) u_dut_a (
      .clk(clk), .phy_tx_arest(rst), .start(start_a), .abort(abort_a),
      .rom_addr(addr_a), .rom_dout(rom_a), .m_tdata(tdata_a), .m_tvalid(tvalid_a),
      .m_tready(tready_a), .m_tlast(tlast_a), .busy(busy_a), .done(done_a)
   );

   l_stf_seq #(.NUM_REP(2), .WIN_EN(1'b0)) u_dut_b (
      .clk(clk), .phy_tx_arest(rst), .start(start_b), .abort(abort_b),
      .rom_addr(addr_b), .rom_dout(rom_b), .m_tdata(tdata_b), .m_tvalid(tvalid_b),
      .m_tready(tready_b), .m_tlast(tlast_b), .busy(busy_b), .done(done_b)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns in the cycle done is high, or records a timeout.
   task automatic wait_done(input bit sel, input int budget);
      int n;
      n = 0;
      while (((sel ? done_b : done_a) !== 1'b1) && n < budget) begin
         tick();
         n++;
      end
      chk(sel ? "done_b_wait" : "done_a_wait", {63'd0, sel ? done_b : done_a}, 64'd1);
   endtask

   // Monitors: pop and compare on every handshake the DUT will accept.
   always @(negedge clk) begin
      if (!rst) begin
         if (done_a) dones_a++;
         if (tvalid_a && tready_a) begin
            beats_a++;
            if (q_a.size() == 0) chk("a_unexpected_beat", {31'd0, tlast_a, tdata_a}, 64'd0);
            else chk("a_beat", {31'd0, tlast_a, tdata_a}, {31'd0, q_a.pop_front()});
         end
         if (done_b) dones_b++;
         if (tvalid_b && tready_b) begin
            beats_b++;
            if (q_b.size() == 0) chk("b_unexpected_beat", {31'd0, tlast_b, tdata_b}, 64'd0);
            else chk("b_beat", {31'd0, tlast_b, tdata_b}, {31'd0, q_b.pop_front()});
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic push_a_field();
      for (int unsigned k = 0; k < 160; k++) q_a.push_back(exp_beat(k, 10, 1'b1));
   endtask

   task automatic chk_a_idle_zero(input string tag);
      chk({tag, "_tvalid"}, {63'd0, tvalid_a}, 64'd0);
      chk({tag, "_tlast"},  {63'd0, tlast_a},  64'd0);
      chk({tag, "_busy"},   {63'd0, busy_a},   64'd0);
      chk({tag, "_done"},   {63'd0, done_a},   64'd0);
      chk({tag, "_addr"},   {60'd0, addr_a},   64'd0);
   endtask

   initial begin
      int base, dbase, nv;
      rst = 1'b1;
      start_a = 1'b0; abort_a = 1'b0; tready_a = 1'b1;
      start_b = 1'b0; abort_b = 1'b0; tready_b = 1'b1;
      repeat (3) tick();
      chk_a_idle_zero("reset");
      chk("reset_tdata", {32'd0, tdata_a}, 64'd0);
      chk("reset_b_tvalid", {63'd0, tvalid_b}, 64'd0);
      rst = 1'b0;
      tick();

      // Basic field
      push_a_field();
      base = beats_a; dbase = dones_a;
      start_a = 1'b1;
      chk("t1_busy_before", {63'd0, busy_a}, 64'd0);
      tick();
      start_a = 1'b0;
      chk("t1_first_valid", {63'd0, tvalid_a}, 64'd1);
      nv = 0;
      for (int i = 0; i < 160; i++) begin
         if (tvalid_a && busy_a) nv++;
         tick();
      end
      chk("t1_valid_busy_cycles", 64'(nv), 64'd160);
      chk("t1_end_tvalid", {63'd0, tvalid_a}, 64'd0);
      chk("t1_end_busy", {63'd0, busy_a}, 64'd0);
      chk("t1_done", {63'd0, done_a}, 64'd1);
      tick();
      chk("t1_done_one_cycle", {63'd0, done_a}, 64'd0);
      chk("t1_beats", 64'(beats_a - base), 64'd160);
      chk("t1_dones", 64'(dones_a - dbase), 64'd1);
      chk("t1_queue_empty", 64'(q_a.size()), 64'd0);

      // Backpressure at beat 5
      push_a_field();
      base = beats_a;
      start_a = 1'b1; tick(); start_a = 1'b0;
      repeat (5) tick();
      tready_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_stall_tdata", {32'd0, tdata_a}, 64'h0000042a);
         chk("t2_stall_tvalid", {63'd0, tvalid_a}, 64'd1);
      end
      tready_a = 1'b1;
      wait_done(1'b0, 400);
      chk("t2_beats", 64'(beats_a - base), 64'd160);
      chk("t2_queue_empty", 64'(q_a.size()), 64'd0);

      // Short unwindowed field on instance B
      for (int unsigned k = 0; k < 32; k++) q_b.push_back(exp_beat(k, 2, 1'b0));
      base = beats_b;
      start_b = 1'b1; tick(); start_b = 1'b0;
      chk("t3_beat0", {32'd0, tdata_b}, 64'hfd0efd0e);
      wait_done(1'b1, 100);
      chk("t3_beats", 64'(beats_b - base), 64'd32);
      chk("t3_queue_empty", 64'(q_b.size()), 64'd0);

      // Abort coincident with handshake of beat 40
      tick();
      push_a_field();
      base = beats_a; dbase = dones_a;
      start_a = 1'b1; tick(); start_a = 1'b0;
      repeat (40) tick();
      abort_a = 1'b1; tick(); abort_a = 1'b0;
      chk_a_idle_zero("t4_abort");
      q_a.delete();
      repeat (3) tick();
      chk("t4_no_done", 64'(dones_a - dbase), 64'd0);
      chk("t4_beats", 64'(beats_a - base), 64'd41);
      start_a = 1'b1; abort_a = 1'b1; tick(); start_a = 1'b0; abort_a = 1'b0;
      chk("t4_abort_wins_busy", {63'd0, busy_a}, 64'd0);
      chk("t4_abort_wins_tvalid", {63'd0, tvalid_a}, 64'd0);
      push_a_field();
      start_a = 1'b1; tick(); start_a = 1'b0;
      chk("t4_restart_beat0", {32'd0, tdata_a}, 64'hfe87fe87);
      wait_done(1'b0, 400);
      chk("t4_queue_empty", 64'(q_a.size()), 64'd0);

      // Start while busy, start on final handshake, start in done cycle
      tick();
      push_a_field();
      base = beats_a; dbase = dones_a;
      start_a = 1'b1; tick(); start_a = 1'b0;
      repeat (10) tick();
      start_a = 1'b1; tick(); start_a = 1'b0;
      repeat (148) tick();
      start_a = 1'b1; tick();
      chk("t5_done", {63'd0, done_a}, 64'd1);
      chk("t5_tvalid_after_final", {63'd0, tvalid_a}, 64'd0);
      chk("t5_busy_after_final", {63'd0, busy_a}, 64'd0);
      chk("t5_beats_first", 64'(beats_a - base), 64'd160);
      push_a_field();
      tick(); start_a = 1'b0;
      chk("t5_relaunch_tvalid", {63'd0, tvalid_a}, 64'd1);
      chk("t5_relaunch_beat0", {32'd0, tdata_a}, 64'hfe87fe87);
      wait_done(1'b0, 400);
      chk("t5_beats_total", 64'(beats_a - base), 64'd320);
      tick();
      chk("t5_dones", 64'(dones_a - dbase), 64'd2);

      // Synchronous reset at beat 80
      push_a_field();
      base = beats_a; dbase = dones_a;
      start_a = 1'b1; tick(); start_a = 1'b0;
      repeat (80) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      chk_a_idle_zero("t6_reset");
      chk("t6_reset_tdata", {32'd0, tdata_a}, 64'd0);
      chk("t6_beats", 64'(beats_a - base), 64'd80);
      q_a.delete();
      repeat (3) tick();
      chk("t6_no_done", 64'(dones_a - dbase), 64'd0);
      push_a_field();
      base = beats_a;
      start_a = 1'b1; tick(); start_a = 1'b0;
      chk("t6_restart_tvalid", {63'd0, tvalid_a}, 64'd1);
      chk("t6_restart_beat0", {32'd0, tdata_a}, 64'hfe87fe87);
      wait_done(1'b0, 400);
      chk("t6_beats_after", 64'(beats_a - base), 64'd160);
      chk("t6_queue_empty", 64'(q_a.size()), 64'd0);

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
